heading_display: RTL and testbench
==================================

# heading_display

Downstream display stage of the heading system. It consumes the two 7-bit register values `dataP` and `dataQ` produced by the heading block. Each value is converted sequentially from binary to three BCD digits, and the six resulting digits are time-multiplexed onto a single active-high 7-segment bus. Conversion runs only when an input value changes, and the display keeps showing the last converted pair while a conversion is in progress.

## Interface

Parameters:
- `REFRESH_DIV`, default 4: clock cycles each digit stays enabled before the scan advances. Legal range is 1..65535.

Ports:
- `clock`, input, 1 bit: system clock; all state changes on the posedge.
- `reset_n`, input, 1 bit: asynchronous, active-low reset.
- `dataP`, input, 7 bits: P register value from the heading block, unsigned 0..127.
- `dataQ`, input, 7 bits: Q register value from the heading block, unsigned 0..127.
- `seg`, output, 7 bits: segment drive, active-high. `seg[0]`=a … `seg[6]`=g.
- `digit_en`, output, 6 bits: one-hot digit select, active-high.
- `busy`, output, 1 bit: high while a conversion or update is in progress.
- `valid`, output, 1 bit: display registers hold a completed conversion.

## Operation

- **Reset values:** `seg`=0, `digit_en`=6'b000001, `busy`=0, `valid`=0. FSM in IDLE, display registers 0, scan index 0, refresh counter 0, `capP`/`capQ`=0.
- **FSM: IDLE → CONV → UPDATE → IDLE.**
  - **IDLE:** if `valid`=0, or `dataP`≠`capP`, or `dataQ`≠`capQ`:
    - latch `dataP`/`dataQ` into `capP`/`capQ` and into two 7-bit shift registers;
    - clear both 12-bit BCD accumulators and the step counter;
    - go to CONV.
  - **CONV:** double-dabble on both values in parallel.
    - Each edge: add 3 to every BCD nibble ≥5, then shift {BCD, bin} left by 1.
    - Step counter runs 0..6. After the 7th shift, go to UPDATE.
  - **UPDATE:** copy both BCD results into the six display digit registers, set `valid`=1, go to IDLE.
- Input changes during CONV/UPDATE are ignored. They are detected in the next IDLE cycle because the comparison is against `capP`/`capQ`. Conversion never restarts mid-way.
- `busy` is the registered flag (state≠IDLE).
- **Digit map** (scan index i, `digit_en`=1<<i):
  - 0 = P units, 1 = P tens, 2 = P hundreds;
  - 3 = Q units, 4 = Q tens, 5 = Q hundreds.
- **Scan:**
  - The refresh counter counts 0..`REFRESH_DIV`-1.
  - On wrap, the index advances 0→5 and then back to 0.
  - Scanning runs in every FSM state, including before `valid` goes high.
- **Segment decode** of the selected digit (hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Digit codes 10–15 are unreachable; decode them to 00.
  - `seg`=0 while `valid`=0.
- **Width rules:** the maximum input is 127, so the hundreds digit is only 0 or 1. The BCD accumulator must not overflow for any input in 0..127.
- **Reset mid-operation:** asserting `reset_n` low during CONV or UPDATE immediately forces all reset values. After release, the first IDLE edge starts a fresh conversion because `valid`=0.

## Timing

- `seg` and `digit_en` are registered, with no combinational path from inputs to outputs.
- **Conversion latency:** input pair stable before IDLE edge k →
  - edge k: capture, `busy`=1;
  - edges k+1..k+7: shifts;
  - edge k+8: UPDATE writes the display, `valid`=1 (if not already), `busy`=0.
- New digits appear on `seg` from edge k+9 onward, when their index is selected.
- A back-to-back change arriving during a conversion starts the next capture at edge k+9 at the earliest.
- Each `digit_en` bit is high for exactly `REFRESH_DIV` cycles per 6×`REFRESH_DIV`-cycle frame.

## Configuration

- **`HEADING_DISPLAY_BLANK_EN` defined:** leading-zero blanking per value.
  - The hundreds digit shows `seg`=0 when it is 0.
  - The tens digit shows `seg`=0 when both hundreds and tens are 0.
  - The units digit is always shown.
- **Not defined:** all six digits are always decoded, e.g. 5 displays as "005".

## Test plan

- **Reset:** hold `reset_n`=0 → `seg`=0, `digit_en`=000001, `busy`=0, `valid`=0. Release with `dataP`=0, `dataQ`=0 → `busy` goes high at the next edge; `valid`=1 nine edges later; all digits decode 3F (macro off).
- **Nominal values:** `dataP`=36, `dataQ`=56, `REFRESH_DIV`=4 → after 9 edges, scan shows indices 0..5 = 7D, 4F, 3F, 7D, 6D, 3F, each held 4 cycles.
- **Boundary values:** `dataP`=127, `dataQ`=100 → P digits 07, 5B, 06; Q digits 3F, 3F, 06. No illegal codes appear.
- **Change during conversion:** change `dataP` 36→99 three edges into CONV → the first result shows 36. A second conversion starts automatically, and 99 (6F, 6F, 3F) is displayed 18 edges after the first capture.
- **Async reset during conversion:** pulse `reset_n` low at CONV step 3 → outputs go to reset values immediately (without waiting for a clock edge), and a full reconversion follows after release.
- **Blanking (`HEADING_DISPLAY_BLANK_EN` defined):** `dataP`=5, `dataQ`=40 → P hundreds and tens show 00, P units shows 6D; Q hundreds shows 00, Q tens shows 66, Q units shows 3F.

Source files
------------

// File: rtl/heading_display.sv
// Display stage: double-dabble converts dataP/dataQ to BCD and scans six digits onto a 7-segment bus.
// Optional build macro HEADING_DISPLAY_BLANK_EN enables leading-zero blanking per value.
module heading_display #(
  parameter int REFRESH_DIV = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [6:0] dataP,
  input  logic [6:0] dataQ,
  output logic [6:0] seg,
  output logic [5:0] digit_en,
  output logic       busy,
  output logic       valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(REFRESH_DIV - 1);

  state_t      state;
  state_t      state_next;
  logic        start;
  logic        busy_next;
  logic [6:0]  cap_p;
  logic [6:0]  cap_q;
  logic [6:0]  sh_p;
  logic [6:0]  sh_q;
  logic [11:0] bcd_p;
  logic [11:0] bcd_q;
  logic [2:0]  step;
  logic [11:0] disp_p;
  logic [11:0] disp_q;
  logic [15:0] refresh_cnt;
  logic [2:0]  scan_idx;
  logic [2:0]  idx_next;
  logic [3:0]  code;
  logic        blank;
  logic [6:0]  seg_next;

  function automatic logic [3:0] add3(input logic [3:0] n);
    logic [3:0] r;
    if (n >= 4'd5) begin
      r = n + 4'd3;
    end else begin
      r = n;
    end
    return r;
  endfunction

  // One double-dabble step: correct every nibble, then shift {bcd, bin} left.
  function automatic logic [18:0] dabble(input logic [11:0] bcd, input logic [6:0] bin);
    logic [18:0] t;
    t = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0]), bin};
    return {t[17:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; a new capture is needed whenever the shown pair is stale.
  always_comb begin
    start      = !valid || (dataP != cap_p) || (dataQ != cap_q);
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CONV;
        end else begin
          state_next = IDLE;
        end
      end
      CONV: begin
        if (step == 3'd6) begin
          state_next = UPDATE;
        end else begin
          state_next = CONV;
        end
      end
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM output logic.
  always_comb begin
    busy_next = (state_next != IDLE);
  end

  // Conversion datapath, capture registers and display digit registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cap_p  <= 7'd0;
      cap_q  <= 7'd0;
      sh_p   <= 7'd0;
      sh_q   <= 7'd0;
      bcd_p  <= 12'd0;
      bcd_q  <= 12'd0;
      step   <= 3'd0;
      disp_p <= 12'd0;
      disp_q <= 12'd0;
      valid  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      busy <= busy_next;
      case (state)
        IDLE: begin
          if (start) begin
            cap_p <= dataP;
            cap_q <= dataQ;
            sh_p  <= dataP;
            sh_q  <= dataQ;
            bcd_p <= 12'd0;
            bcd_q <= 12'd0;
            step  <= 3'd0;
          end else begin
            step <= 3'd0;
          end
        end
        CONV: begin
          {bcd_p, sh_p} <= dabble(bcd_p, sh_p);
          {bcd_q, sh_q} <= dabble(bcd_q, sh_q);
          step          <= step + 3'd1;
        end
        UPDATE: begin
          disp_p <= bcd_p;
          disp_q <= bcd_q;
          valid  <= 1'b1;
        end
        default: step <= 3'd0;
      endcase
    end
  end

  // Scan index advance and selected-digit decode.
  always_comb begin
    idx_next = scan_idx;
    code     = 4'd0;
    blank    = 1'b0;
    if (refresh_cnt == DIV_LAST) begin
      if (scan_idx == 3'd5) begin
        idx_next = 3'd0;
      end else begin
        idx_next = scan_idx + 3'd1;
      end
    end else begin
      idx_next = scan_idx;
    end
    case (idx_next)
      3'd0:    code = disp_p[3:0];
      3'd1:    code = disp_p[7:4];
      3'd2:    code = disp_p[11:8];
      3'd3:    code = disp_q[3:0];
      3'd4:    code = disp_q[7:4];
      3'd5:    code = disp_q[11:8];
      default: code = 4'd0;
    endcase
`ifdef HEADING_DISPLAY_BLANK_EN
    case (idx_next)
      3'd1:    blank = (disp_p[11:8] == 4'd0) && (disp_p[7:4] == 4'd0);
      3'd2:    blank = (disp_p[11:8] == 4'd0);
      3'd4:    blank = (disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0);
      3'd5:    blank = (disp_q[11:8] == 4'd0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    if (valid && !blank) begin
      seg_next = seg7(code);
    end else begin
      seg_next = 7'h00;
    end
  end

  // Refresh counter, scan index and registered display outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      refresh_cnt <= 16'd0;
      scan_idx    <= 3'd0;
      digit_en    <= 6'b000001;
      seg         <= 7'h00;
    end else begin
      if (refresh_cnt == DIV_LAST) begin
        refresh_cnt <= 16'd0;
      end else begin
        refresh_cnt <= refresh_cnt + 16'd1;
      end
      scan_idx <= idx_next;
      digit_en <= 6'b000001 << idx_next;
      seg      <= seg_next;
    end
  end

endmodule

// File: tb/tb_heading_display.sv
// Self-checking bench for heading_display: decimal reference model checked every cycle plus literal scans.
module tb_heading_display;

  localparam int RD = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] dataP = 7'd0;
  logic [6:0] dataQ = 7'd0;
  logic [6:0] seg;
  logic [5:0] digit_en;
  logic       busy;
  logic       valid;

  int checks = 0;
  int passes = 0;

  heading_display #(.REFRESH_DIV(RD)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .dataP   (dataP),
    .dataQ   (dataQ),
    .seg     (seg),
    .digit_en(digit_en),
    .busy    (busy),
    .valid   (valid)
  );

  always #5 clock = ~clock;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Expected segment pattern for decimal position pos (0 units, 1 tens, 2 hundreds) of value v.
  function automatic logic [6:0] seg_of(input int v, input int pos);
    int d;
    d = (pos == 0) ? v % 10 : (pos == 1) ? (v / 10) % 10 : v / 100;
`ifdef HEADING_DISPLAY_BLANK_EN
    if (pos == 2 && v < 100) return 7'h00;
    if (pos == 1 && v < 10) return 7'h00;
`endif
    return seg_tab[d];
  endfunction

  // Reference model: a capture is followed 8 edges later by the display taking the captured pair.
  int         m_ticks = 0;
  int         m_timer = 0;
  logic       m_busy = 1'b0;
  logic       m_valid = 1'b0;
  int         m_cp = 0, m_cq = 0, m_dp = 0, m_dq = 0;
  logic [6:0] m_seg = 7'h00;
  logic [5:0] m_den = 6'b000001;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_ticks <= 0; m_timer <= 0; m_busy <= 1'b0; m_valid <= 1'b0;
      m_cp <= 0; m_cq <= 0; m_dp <= 0; m_dq <= 0;
      m_seg <= 7'h00; m_den <= 6'b000001;
    end else begin
      m_ticks <= m_ticks + 1;
      m_den   <= 6'b000001 << (((m_ticks + 1) / RD) % 6);
      m_seg   <= m_valid ? seg_of(((((m_ticks + 1) / RD) % 6) < 3) ? m_dp : m_dq,
                                  (((m_ticks + 1) / RD) % 6) % 3) : 7'h00;
      if (!m_busy) begin
        if (!m_valid || int'(dataP) != m_cp || int'(dataQ) != m_cq) begin
          m_cp <= int'(dataP); m_cq <= int'(dataQ);
          m_busy <= 1'b1; m_timer <= 8;
        end
      end else begin
        m_timer <= m_timer - 1;
        if (m_timer == 1) begin
          m_dp <= m_cp; m_dq <= m_cq; m_valid <= 1'b1; m_busy <= 1'b0;
        end
      end
    end
  end

  always @(negedge clock) begin
    chk("seg", seg, m_seg);
    chk("digit_en", digit_en, m_den);
    chk("busy", busy, m_busy);
    chk("valid", valid, m_valid);
  end

  task automatic wait_conv();
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 5) begin @(negedge clock); n++; end
    chk("busy_rise", busy, 1);
    n = 0;
    while (busy !== 1'b0 && n < 20) begin @(negedge clock); n++; end
    chk("busy_fall", busy, 0);
    @(negedge clock);
  endtask

  // Align to the start of a frame, then check each digit over its full hold time.
  task automatic check_scan(input string nm, input logic [41:0] exp);
    int n;
    n = 0;
    while (digit_en == 6'b000001 && n < 40) begin @(negedge clock); n++; end
    n = 0;
    while (digit_en != 6'b000001 && n < 40) begin @(negedge clock); n++; end
    chk({nm, "_align"}, digit_en, 6'b000001);
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < RD; j++) begin
        chk({nm, "_seg"}, seg, exp[i*7 +: 7]);
        chk({nm, "_den"}, digit_en, 6'b000001 << i);
        @(negedge clock);
      end
    end
  endtask

  initial begin
    int n;
    // Model pins against hand-computed decodes.
    chk("model_127_units", seg_of(127, 0), 7'h07);
    chk("model_127_tens", seg_of(127, 1), 7'h5B);
    chk("model_36_units", seg_of(36, 0), 7'h7D);
    chk("model_100_hund", seg_of(100, 2), 7'h06);

    repeat (3) @(negedge clock);
    chk("rst_seg", seg, 7'h00);
    chk("rst_den", digit_en, 6'b000001);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);

    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_busy", busy, 1);
    n = 1;
    while (valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    chk("valid_latency", n, 9);
    @(negedge clock);
`ifdef HEADING_DISPLAY_BLANK_EN
    check_scan("zeros", {7'h00, 7'h00, 7'h3F, 7'h00, 7'h00, 7'h3F});
`else
    check_scan("zeros", {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F});
`endif

    dataP = 7'd36; dataQ = 7'd56;
    wait_conv();
`ifdef HEADING_DISPLAY_BLANK_EN
    check_scan("nominal", {7'h00, 7'h6D, 7'h7D, 7'h00, 7'h4F, 7'h7D});
`else
    check_scan("nominal", {7'h3F, 7'h6D, 7'h7D, 7'h3F, 7'h4F, 7'h7D});
`endif

    dataP = 7'd127; dataQ = 7'd100;
    wait_conv();
    check_scan("boundary", {7'h06, 7'h3F, 7'h3F, 7'h06, 7'h5B, 7'h07});

    // Change P three edges into the conversion.
    dataP = 7'd36; dataQ = 7'd56;
    @(negedge clock);
    chk("chg_capture", busy, 1);
    repeat (3) @(negedge clock);
    dataP = 7'd99;
    repeat (5) @(negedge clock);
    chk("chg_first_done", busy, 0);
    chk("chg_first_valid", valid, 1);
    @(negedge clock);
    chk("chg_second_capture", busy, 1);
    wait_conv();
`ifdef HEADING_DISPLAY_BLANK_EN
    check_scan("change", {7'h00, 7'h6D, 7'h7D, 7'h00, 7'h6F, 7'h6F});
`else
    check_scan("change", {7'h3F, 7'h6D, 7'h7D, 7'h3F, 7'h6F, 7'h6F});
`endif

    // Asynchronous reset during conversion.
    dataP = 7'd50; dataQ = 7'd7;
    repeat (4) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_seg", seg, 7'h00);
    chk("arst_den", digit_en, 6'b000001);
    chk("arst_busy", busy, 0);
    chk("arst_valid", valid, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    wait_conv();
`ifdef HEADING_DISPLAY_BLANK_EN
    check_scan("reconv", {7'h00, 7'h00, 7'h07, 7'h00, 7'h6D, 7'h3F});
`else
    check_scan("reconv", {7'h3F, 7'h3F, 7'h07, 7'h3F, 7'h6D, 7'h3F});
`endif

    dataP = 7'd5; dataQ = 7'd40;
    wait_conv();
`ifdef HEADING_DISPLAY_BLANK_EN
    check_scan("blank", {7'h00, 7'h66, 7'h3F, 7'h00, 7'h00, 7'h6D});
`else
    check_scan("blank", {7'h3F, 7'h66, 7'h3F, 7'h3F, 7'h3F, 7'h6D});
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
